// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard and forwarding controller built around an EX/MEM/WB destination scoreboard.
// Define BRANCH_STATS_EN to build the branch/taken/stall statistics counters.
module branch_hazard_ctrl #(
  parameter int MAX_STALL = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic             id_is_bne,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic             zero,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall,
  output logic             flush_ifid,
  output logic             branch_taken,
  output logic             hazard_err,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_stalls
);

  localparam int SCW = $clog2(MAX_STALL + 1);

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] dst;
  } sb_entry_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  sb_entry_t      r_sb_ex;
  sb_entry_t      r_sb_mem;
  sb_entry_t      r_sb_wb;
  sb_entry_t      w_sb_id;
  state_t         r_state;
  state_t         w_state_nxt;
  logic [SCW-1:0] r_stall_cnt;
  logic [SCW-1:0] w_stall_cnt_nxt;
  logic           r_hazard_err;
  logic           w_hazard_err_nxt;
  logic           w_ex_hit;
  logic           w_ex_load_hit;
  logic           w_mem_load_hit;
  logic           w_stall;
  logic           w_resolve;
  logic           w_taken;

  function automatic logic hits(input sb_entry_t e, input logic [4:0] r);
    return e.valid && e.regwrite && (e.dst == r) && (r != 5'd0);
  endfunction

  // A load still in MEM has no data yet, so it can only be forwarded once it reaches WB.
  function automatic logic [1:0] fwd_sel(input sb_entry_t mem, input sb_entry_t wb,
                                         input logic [4:0] r);
    logic [1:0] sel;
    sel = 2'b00;
    if (hits(mem, r) && !mem.memtoreg) sel = 2'b10;
    else if (hits(wb, r))              sel = 2'b01;
    return sel;
  endfunction

  assign w_sb_id        = id_valid ? {1'b1, id_regwrite, id_memtoreg, id_dst} : '0;
  assign w_ex_hit       = hits(r_sb_ex, id_rs) || hits(r_sb_ex, id_rt);
  assign w_ex_load_hit  = w_ex_hit && r_sb_ex.memtoreg;
  assign w_mem_load_hit = (hits(r_sb_mem, id_rs) || hits(r_sb_mem, id_rt)) && r_sb_mem.memtoreg;

  // Gating with rst_n keeps every output at 0 while reset is held, whatever the ID inputs are.
  assign w_stall   = rst_n && id_valid &&
                     ((id_is_branch && (w_ex_hit || w_mem_load_hit)) || w_ex_load_hit);
  assign w_resolve = rst_n && id_valid && id_is_branch && !w_stall;
  assign w_taken   = w_resolve && (zero ^ id_is_bne);

  assign forward_a    = fwd_sel(r_sb_mem, r_sb_wb, id_rs);
  assign forward_b    = fwd_sel(r_sb_mem, r_sb_wb, id_rt);
  assign stall        = w_stall;
  assign branch_taken = w_taken;
  assign flush_ifid   = w_taken;
  assign hazard_err   = r_hazard_err;

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_stall_cnt_nxt  = r_stall_cnt;
    w_hazard_err_nxt = r_hazard_err;
    case (r_state)
      S_RUN: begin
        if (w_stall) begin
          w_state_nxt     = S_HOLD;
          w_stall_cnt_nxt = SCW'(1);
        end else begin
          w_stall_cnt_nxt = '0;
        end
      end
      S_HOLD: begin
        if (w_stall) begin
          if (r_stall_cnt != SCW'(MAX_STALL)) w_stall_cnt_nxt = r_stall_cnt + 1'b1;
        end else begin
          w_state_nxt     = S_RUN;
          w_stall_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = S_RUN;
        w_stall_cnt_nxt = '0;
      end
    endcase
    if (w_stall_cnt_nxt == SCW'(MAX_STALL)) w_hazard_err_nxt = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all stages shift from the same old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_ex      <= '0;
      r_sb_mem     <= '0;
      r_sb_wb      <= '0;
      r_state      <= S_RUN;
      r_stall_cnt  <= '0;
      r_hazard_err <= 1'b0;
    end else begin
      r_sb_ex      <= w_stall ? sb_entry_t'('0) : w_sb_id;
      r_sb_mem     <= r_sb_ex;
      r_sb_wb      <= r_sb_mem;
      r_state      <= w_state_nxt;
      r_stall_cnt  <= w_stall_cnt_nxt;
      r_hazard_err <= w_hazard_err_nxt;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_stat_branches;
  logic [CNT_W-1:0] r_stat_taken;
  logic [CNT_W-1:0] r_stat_stalls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_branches <= '0;
      r_stat_taken    <= '0;
      r_stat_stalls   <= '0;
    end else begin
      if (w_resolve) r_stat_branches <= r_stat_branches + 1'b1;
      if (w_taken)   r_stat_taken    <= r_stat_taken + 1'b1;
      if (w_stall)   r_stat_stalls   <= r_stat_stalls + 1'b1;
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_taken    = r_stat_taken;
  assign stat_stalls   = r_stat_stalls;
`else
  assign stat_branches = '0;
  assign stat_taken    = '0;
  assign stat_stalls   = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scoreboard bench for branch_hazard_ctrl: each stimulus row pushes its expected outputs, popped at sample time.
`timescale 1ns/1ps
module tb_branch_hazard_ctrl;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic       valid;
    logic       br;
    logic       bne;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       rw;
    logic       mtr;
    logic       zero;
  } stim_t;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       stall;
    logic       taken;
    logic       flush;
    logic       err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid, id_is_branch, id_is_bne, id_regwrite, id_memtoreg, zero;
  logic [4:0]       id_rs, id_rt, id_dst;
  logic [1:0]       forward_a, forward_b;
  logic             stall, flush_ifid, branch_taken, hazard_err;
  logic [CNT_W-1:0] stat_branches, stat_taken, stat_stalls;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int unsigned m_br = 0, m_tk = 0, m_st = 0;

  branch_hazard_ctrl #(.MAX_STALL(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_is_branch(id_is_branch), .id_is_bne(id_is_bne),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .zero(zero),
    .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
    .flush_ifid(flush_ifid), .branch_taken(branch_taken), .hazard_err(hazard_err),
    .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_stalls(stat_stalls)
  );

  always #5 clk = ~clk;

  function automatic stim_t alu(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
    return '{valid: 1'b1, br: 1'b0, bne: 1'b0, rs: rs, rt: rt, dst: dst, rw: 1'b1, mtr: 1'b0, zero: 1'b0};
  endfunction

  function automatic stim_t load(input logic [4:0] dst, input logic [4:0] rs);
    return '{valid: 1'b1, br: 1'b0, bne: 1'b0, rs: rs, rt: 5'd0, dst: dst, rw: 1'b1, mtr: 1'b1, zero: 1'b0};
  endfunction

  function automatic stim_t br(input logic bne, input logic [4:0] rs, input logic [4:0] rt,
                               input logic z);
    return '{valid: 1'b1, br: 1'b1, bne: bne, rs: rs, rt: rt, dst: 5'd0, rw: 1'b0, mtr: 1'b0, zero: z};
  endfunction

  function automatic exp_t ex(input logic [1:0] fa, input logic [1:0] fb, input logic st,
                              input logic tk, input logic er);
    return '{fa: fa, fb: fb, stall: st, taken: tk, flush: tk, err: er};
  endfunction

  function automatic exp_t observed();
    return {forward_a, forward_b, stall, branch_taken, flush_ifid, hazard_err};
  endfunction

  task automatic drive(input stim_t s);
    id_valid     = s.valid;
    id_is_branch = s.br;
    id_is_bne    = s.bne;
    id_rs        = s.rs;
    id_rt        = s.rt;
    id_dst       = s.dst;
    id_regwrite  = s.rw;
    id_memtoreg  = s.mtr;
    zero         = s.zero;
  endtask

  task automatic model_stats(input stim_t s, input exp_t e);
    if (e.stall) m_st++;
    if (s.valid && s.br && !e.stall) m_br++;
    if (e.taken) m_tk++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive('0);
    end
  endtask

  task automatic test_reset();
    exp_t got;
    rst_n = 1'b0;
    drive('0);
    #3;
    got = observed();
    n_checks++;
    if (got !== exp_t'('0) || stat_branches !== '0 || stat_taken !== '0 || stat_stalls !== '0) begin
      n_fail++;
      $display("FAIL reset: got outputs=%b stats=%0d/%0d/%0d, want all 0", got,
               stat_branches, stat_taken, stat_stalls);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_branch();
    stim_t s[3];
    exp_t  e[3];
    exp_t  got, want;
    s[0] = alu(5'd3, 5'd1, 5'd2);     e[0] = ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    s[1] = br(1'b0, 5'd3, 5'd4, 1'b1); e[1] = ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    s[2] = br(1'b0, 5'd3, 5'd4, 1'b1); e[2] = ex(2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(s[i]);
      exp_q.push_back(e[i]);
      #1;
      got  = observed();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL alu_branch row%0d: got %b want %b (fa,fb,stall,taken,flush,err)", i, got, want);
      end
      model_stats(s[i], want);
    end
  endtask

  task automatic test_load_branch();
    stim_t s[4];
    exp_t  e[4];
    exp_t  got, want;
    s[0] = load(5'd5, 5'd1);           e[0] = ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    s[1] = br(1'b1, 5'd5, 5'd0, 1'b0); e[1] = ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    s[2] = br(1'b1, 5'd5, 5'd0, 1'b0); e[2] = ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    s[3] = br(1'b1, 5'd5, 5'd0, 1'b0); e[3] = ex(2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(s[i]);
      exp_q.push_back(e[i]);
      #1;
      got  = observed();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL load_branch row%0d: got %b want %b (fa,fb,stall,taken,flush,err)", i, got, want);
      end
      model_stats(s[i], want);
    end
  endtask

  task automatic test_load_use();
    stim_t s[4];
    exp_t  e[4];
    exp_t  got, want;
    s[0] = load(5'd2, 5'd1);           e[0] = ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    s[1] = alu(5'd8, 5'd2, 5'd7);      e[1] = ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    s[2] = alu(5'd8, 5'd2, 5'd7);      e[2] = ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    s[3] = br(1'b1, 5'd2, 5'd9, 1'b1); e[3] = ex(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(s[i]);
      exp_q.push_back(e[i]);
      #1;
      got  = observed();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL load_use row%0d: got %b want %b (fa,fb,stall,taken,flush,err)", i, got, want);
      end
      model_stats(s[i], want);
    end
  endtask

  task automatic test_double_producer();
    stim_t s[4];
    exp_t  e[4];
    exp_t  got, want;
    s[0] = alu(5'd6, 5'd1, 5'd1);      e[0] = ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    s[1] = alu(5'd6, 5'd1, 5'd1);      e[1] = ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    s[2] = alu(5'd0, 5'd0, 5'd0);      s[2].rw = 1'b0;
                                       e[2] = ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    s[3] = br(1'b0, 5'd6, 5'd6, 1'b0); e[3] = ex(2'b10, 2'b10, 1'b0, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(s[i]);
      exp_q.push_back(e[i]);
      #1;
      got  = observed();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL double_producer row%0d: got %b want %b (fa,fb,stall,taken,flush,err)", i, got, want);
      end
      model_stats(s[i], want);
    end
  endtask

  task automatic test_r0();
    stim_t s[2];
    exp_t  e[2];
    exp_t  got, want;
    s[0] = alu(5'd0, 5'd1, 5'd2);      e[0] = ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    s[1] = br(1'b0, 5'd0, 5'd0, 1'b1); e[1] = ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    idle(3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(s[i]);
      exp_q.push_back(e[i]);
      #1;
      got  = observed();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL r0 row%0d: got %b want %b (fa,fb,stall,taken,flush,err)", i, got, want);
      end
      model_stats(s[i], want);
    end
  endtask

  task automatic test_invalid();
    stim_t s[3];
    exp_t  e[3];
    exp_t  got, want;
    s[0] = alu(5'd3, 5'd1, 5'd2);      e[0] = ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    s[1] = br(1'b0, 5'd3, 5'd0, 1'b1); s[1].valid = 1'b0;
                                       e[1] = ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    s[2] = br(1'b0, 5'd3, 5'd4, 1'b1); e[2] = ex(2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(s[i]);
      exp_q.push_back(e[i]);
      #1;
      got  = observed();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL invalid row%0d: got %b want %b (fa,fb,stall,taken,flush,err)", i, got, want);
      end
      model_stats(s[i], want);
    end
  endtask

  task automatic test_stats(input string tag);
    logic [CNT_W-1:0] w_br, w_tk, w_st;
`ifdef BRANCH_STATS_EN
    w_br = CNT_W'(m_br);
    w_tk = CNT_W'(m_tk);
    w_st = CNT_W'(m_st);
`else
    w_br = '0;
    w_tk = '0;
    w_st = '0;
`endif
    @(negedge clk);
    drive('0);
    #1;
    n_checks++;
    if (stat_branches !== w_br || stat_taken !== w_tk || stat_stalls !== w_st) begin
      n_fail++;
      $display("FAIL stats_%s: got br=%0d tk=%0d st=%0d want br=%0d tk=%0d st=%0d", tag,
               stat_branches, stat_taken, stat_stalls, w_br, w_tk, w_st);
    end
  endtask

  task automatic test_watchdog();
    stim_t s;
    exp_t  e[4];
    exp_t  got, want;
    s = '{valid: 1'b1, br: 1'b0, bne: 1'b0, rs: 5'd9, rt: 5'd0, dst: 5'd0, rw: 1'b0, mtr: 1'b0, zero: 1'b0};
    e[0] = ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    e[1] = ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    e[2] = ex(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    e[3] = ex(2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      force dut.r_sb_ex = 8'hE9;
      drive(s);
      exp_q.push_back(e[i]);
      #1;
      got  = observed();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL watchdog cycle%0d: got %b want %b (fa,fb,stall,taken,flush,err)", i, got, want);
      end
    end
    release dut.r_sb_ex;
    rst_n = 1'b0;
    m_br = 0; m_tk = 0; m_st = 0;
    #1;
    got = observed();
    n_checks++;
    if (got !== exp_t'('0)) begin
      n_fail++;
      $display("FAIL watchdog_reset: got %b want 0", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_stall();
    stim_t s[2];
    exp_t  e[2];
    exp_t  got, want;
    s[0] = load(5'd5, 5'd1);           e[0] = ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    s[1] = br(1'b1, 5'd5, 5'd0, 1'b0); e[1] = ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(s[i]);
      exp_q.push_back(e[i]);
      #1;
      got  = observed();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mid_stall row%0d: got %b want %b (fa,fb,stall,taken,flush,err)", i, got, want);
      end
      model_stats(s[i], want);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_br = 0; m_tk = 0; m_st = 0;
    exp_q.push_back(exp_t'('0));
    #1;
    got  = observed();
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want || stat_branches !== '0 || stat_taken !== '0 || stat_stalls !== '0) begin
      n_fail++;
      $display("FAIL mid_stall_reset: got %b stats=%0d/%0d/%0d want %b and 0 stats", got,
               stat_branches, stat_taken, stat_stalls, want);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
    #1;
    got  = observed();
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL after_reset_run: got %b want %b (fa,fb,stall,taken,flush,err)", got, want);
    end
    model_stats(s[1], want);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu_branch();
    test_load_branch();
    test_load_use();
    test_double_producer();
    test_r0();
    test_invalid();
    test_stats("main");
    test_watchdog();
    test_reset_mid_stall();
    test_stats("post_reset");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Hazard and forwarding controller for the ID-stage branch comparator of the 5-stage pipeline. Keeps a private scoreboard of the destination registers held in EX, MEM and WB. From it the block generates the two 2-bit operand selects consumed by the comparator, and the load-use/branch stall. It resolves beq/bne using the comparator's zero output and requests an IF/ID flush on a taken branch.

## Interface
- MAX_STALL, 3: consecutive stall cycles at which `hazard_err` is raised (legal code never exceeds 2).
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  the IF/ID register holds a real instruction.
- id_is_branch  in  1  the ID instruction is beq or bne.
- id_is_bne  in  1  1 = bne, 0 = beq; valid with id_is_branch.
- id_rs, id_rt  in  5 each  source registers of the ID instruction.
- id_dst  in  5  destination register of the ID instruction.
- id_regwrite  in  1  the ID instruction writes id_dst.
- id_memtoreg  in  1  the ID instruction is a load.
- zero  in  1  equality result from the branch comparator.
- forward_a  out  2  comparator select for operand 1.
- forward_b  out  2  comparator select for operand 2.
- stall  out  1  freeze PC and IF/ID, and insert a bubble into EX.
- flush_ifid  out  1  clear IF/ID at the next edge.
- branch_taken  out  1  load the branch target into PC.
- hazard_err  out  1  sticky watchdog flag.
- stat_branches, stat_taken, stat_stalls  out  CNT_W each  statistics counters (see Configuration).

## Operation
- Select encoding:
  - 2'b00: register-file data.
  - 2'b10: MEM-stage ALU result.
  - 2'b01: WB-stage writeback value.
  - 2'b11: never driven.
- Scoreboard: one entry per stage (EX, MEM, WB), each holding {valid, regwrite, memtoreg, dst}.
- Scoreboard update at each clk edge:
  - If stall: EX takes a bubble (all fields 0), MEM takes the old EX entry, WB takes the old MEM entry.
  - If not stall: EX takes the ID fields gated by id_valid; MEM and WB shift as above.
- A stage "hits" register r when its entry has valid, regwrite, dst == r and r != 0.
- Forward selects (apply to rs for forward_a and to rt for forward_b):
  - MEM hits and MEM is not a load: 2'b10.
  - Otherwise, WB hits: 2'b01.
  - Otherwise: 2'b00.
  - MEM has priority over WB.
- Stall conditions, any one of which asserts stall (only when id_valid):
  - (a) id_is_branch and EX hits rs or rt.
  - (b) id_is_branch and MEM is a load that hits rs or rt.
  - (c) EX is a load that hits rs or rt (general load-use, including non-branch instructions).
- Branch resolution (when id_valid, id_is_branch and not stall):
  - branch_taken = zero XOR id_is_bne.
  - flush_ifid = branch_taken.
  - While stall is high, branch_taken and flush_ifid are held at 0.
- FSM states:
  - RUN: default state. RUN → HOLD when stall is high at an edge.
  - HOLD: HOLD stays in HOLD while stall is high. HOLD → RUN when stall is low.
- Stall counter:
  - Counts consecutive stall cycles; it increments in HOLD and resets to 0 on entry to RUN.
  - It saturates at MAX_STALL.
  - When the counter reaches MAX_STALL, hazard_err is set and stays set until reset.
- Reset: all outputs and counters are 0, every scoreboard entry is invalid, and the FSM is in RUN.
  - Reset asserted mid-stall returns the block to RUN immediately (asynchronous).

## Timing
- forward_a, forward_b, stall, branch_taken and flush_ifid are combinational from the current ID inputs, zero and the registered scoreboard. There is no added latency.
- Scoreboard, FSM, counters and hazard_err update on the rising edge only.
- Stall cost per hazard:
  - ALU result feeding a branch: 1 stall cycle. After it the producer is in MEM and is forwarded with 2'b10.
  - Load feeding a branch: 2 stall cycles. The producer is then in WB and is forwarded with 2'b01.
  - Load feeding a non-branch instruction: 1 stall cycle.
- A producer in WB and the register-file read in the same cycle: the WB forward (2'b01) is used.
- Register 0 never forwards and never stalls.
- id_valid = 0: stall = 0 and branch_taken = 0; a bubble enters EX.

## Configuration
- BRANCH_STATS_EN defined:
  - stat_branches increments on each resolved branch (id_valid, id_is_branch, not stall).
  - stat_taken increments on each taken branch.
  - stat_stalls increments on each stall cycle.
  - All three wrap modulo 2^CNT_W and reset to 0.
- BRANCH_STATS_EN undefined: the three stat outputs are tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- ALU result to branch: add r3 in ID, next cycle beq r3,r4. Required: stall = 1 for exactly one cycle, then forward_a = 2'b10 and forward_b = 2'b00. With zero = 1, branch_taken = 1 and flush_ifid = 1.
- Load to branch: lw r5, then bne r5,r0. Required: stall = 1 for two cycles, then forward_a = 2'b01. With zero = 0, branch_taken = 1.
- Load to non-branch: lw r2, then add using r2. Required: one stall cycle and an EX bubble. Branch outputs stay 0.
- Double producer: r6 written in both MEM and WB, then beq r6,r6. Required: forward_a = forward_b = 2'b10 and no stall.
- r0 destination: an instruction writing r0, then beq r0,r0. Required: no stall, selects 2'b00, and taken on zero = 1.
- Watchdog and reset:
  - Force the EX scoreboard entry to a load hitting rs, then hold stall for 3 cycles. Required: hazard_err = 1 after the third stall cycle.
  - Pulse rst_n low mid-stall. Required: all outputs 0 and the FSM in RUN immediately. With BRANCH_STATS_EN defined, the stat counters read 0.
